sift_win3x3_feeder: RTL and testbench
=====================================

# sift_win3x3_feeder

Downstream consumer of the 8-bit pixel FIFO in the SIFT front end. It pulls pixels from the FIFO's read port and keeps two line buffers. It then emits one registered 3x3 neighbourhood per interior pixel to the Gaussian/DoG convolution stage. Flow control is a valid/ready handshake with a one-entry skid register, which absorbs the FIFO's one-cycle read latency.

## Interface
Parameters:
- IMG_W, 320, pixels per line (≥3)
- IMG_H, 240, lines per frame (≥3)
- COL_W, 9, column counter width (2^COL_W ≥ IMG_W)
- ROW_W, 8, row counter width (2^ROW_W ≥ IMG_H)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  8  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO read strobe
- win_ready  in  1  downstream can accept a window
- win_valid  out  1  win_data holds a valid window
- win_data  out  72  tap p[r][c] at bits [(3r+c)*8 +: 8]; r=0 is the oldest line, c=0 the oldest column
- win_row  out  ROW_W  image row of the centre tap (WIN_COORD_EN only)
- win_col  out  COL_W  image column of the centre tap (WIN_COORD_EN only)
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- **Read issue:** fifo_rd_en = !fifo_empty && !skid_full && !(win_valid && !win_ready). The signal is combinational from registered state.
- **Arrival:** pix_vld is the registered copy of fifo_rd_en. fifo_dout is sampled when pix_vld=1.
- **Acceptance:** a pixel (from arrival or from the skid) is accepted when the output register is free, i.e. !win_valid || win_ready.
  - If it arrives while the output is stalled, it goes to the skid.
  - The skid has priority over new arrivals. It cannot overflow, because issue is blocked while it is full.
- **Per accepted pixel at position (row, col):**
  - New column = {lb1[col], lb0[col], pix}, bottom tap = pix.
  - Write lb1[col] ← lb0[col] and lb0[col] ← pix (read-before-write at the same address).
  - Window shifts one column; the new column enters at c=2.
- **Output validity:** win_valid is set on an acceptance with row ≥ 2 and col ≥ 2. The centre tap is then (row−1, col−1).
  - It is cleared on handshake (win_valid && win_ready) when there is no new valid acceptance.
  - Windows straddling the line wrap (col < 2) are never emitted.
- **Counters:**
  - col increments per accepted pixel. At IMG_W−1 it wraps to 0 and row increments.
  - At (IMG_H−1, IMG_W−1) both wrap to 0 and frame_done pulses in the acceptance cycle plus one (registered).
- **Count:** exactly (IMG_W−2)·(IMG_H−2) windows per frame.
- **Reset values:** fifo_rd_en=0, win_valid=0, win_data=0, win_row=0, win_col=0, frame_done=0. Counters, pix_vld and skid are cleared.
  - Line-buffer RAM is not cleared; rows 0–1 are never emitted, so its contents are don't-care.
- **Reset mid-frame:** any in-flight FIFO read is discarded. The next pixel accepted after reset is treated as (0,0).

## Timing
- fifo_rd_en high in cycle t → fifo_dout sampled at the end of t+1 → win_valid high in t+2 (2-cycle latency, no stall).
- Throughput is one pixel per cycle while the FIFO is non-empty and win_ready=1.
- win_data, win_row and win_col are stable while win_valid && !win_ready.
- frame_done coincides with the cycle in which the last window of the frame is presented.

## Configuration
- **WIN_COORD_EN defined:** win_row/win_col ports and their registers exist. They are loaded together with win_data.
- **WIN_COORD_EN undefined:** the ports and registers are removed. Row/col counters remain, because they are needed for validity and frame_done.

## Structure
- **Package sift_win_pkg:** PIX_W=8, WIN_K=3, WIN_TAPS=9, the tap-index function tap(r,c)=(3r+c)*PIX_W, and the default IMG_W/IMG_H.
- **Sub-module sift_line_buf:** an IMG_W×8 RAM with one address, synchronous read-before-write, and a wr_en/addr/din/dout port. It is instantiated twice (lb0, lb1).
- The top level holds the issue logic, skid, counters, window shift registers and the output register.

## Test plan
All scenarios use IMG_W=8, IMG_H=4, FIFO preloaded with pixel = row·16+col.
- **Streaming:** win_ready=1 → 12 windows. The first has centre (1,1) with p00=0x00, p11=0x11, p22=0x22. The last has centre (2,6) with p22=0x37. frame_done pulses once.
- **Latency:** FIFO non-empty from cycle 0 → first fifo_rd_en in cycle 0. Check the value of each tap of the first window against pixel arithmetic. No window appears for pixels of rows 0–1 or cols 0–1.
- **Backpressure:** win_ready=0 for 5 cycles mid-row → win_data is held. fifo_rd_en drops within 1 cycle. The skid captures the in-flight pixel. The sequence resumes with no lost or duplicated window.
- **FIFO underrun:** fifo_empty toggling every other cycle → the same 12 windows in the same order, with gaps.
- **Frame wrap:** two back-to-back frames → 24 windows. The second frame's first window is centre (1,1) with p11=0x11.
- **Mid-frame reset:** rst pulsed after 13 accepted pixels → all outputs 0. The following 32 pixels produce 12 windows from (0,0).

Source files
------------

// File: rtl/sift_win_pkg.sv
// Shared constants, types and the tap-offset helper for the SIFT 3x3 window feeder.
package sift_win_pkg;

   localparam int PIX_W     = 8;
   localparam int WIN_K     = 3;
   localparam int WIN_TAPS  = WIN_K * WIN_K;
   localparam int WIN_W     = WIN_TAPS * PIX_W;
   localparam int IMG_W_DEF = 320;
   localparam int IMG_H_DEF = 240;

   typedef logic [PIX_W-1:0] pix_t;
   // One window column; index 0 is the oldest line, WIN_K-1 the current pixel.
   typedef logic [WIN_K-1:0][PIX_W-1:0] col_t;

   function automatic int tap(input int r, input int c);
      return (WIN_K * r + c) * PIX_W;
   endfunction

endpackage

// File: rtl/sift_win3x3_feeder_if.sv
// FIFO read port and window output bundle of the 3x3 feeder.
// WIN_COORD_EN adds the centre-tap coordinate signals.
interface sift_win3x3_feeder_if
`ifdef WIN_COORD_EN
#(
   parameter int ROW_W = 8,
   parameter int COL_W = 9
)
`endif
();
   import sift_win_pkg::*;

   logic             fifo_empty;
   pix_t             fifo_dout;
   logic             fifo_rd_en;
   logic             win_ready;
   logic             win_valid;
   logic [WIN_W-1:0] win_data;
   logic             frame_done;
`ifdef WIN_COORD_EN
   logic [ROW_W-1:0] win_row;
   logic [COL_W-1:0] win_col;

   modport master (
      input  fifo_empty, fifo_dout, win_ready,
      output fifo_rd_en, win_valid, win_data, frame_done, win_row, win_col
   );
   modport slave (
      output fifo_empty, fifo_dout, win_ready,
      input  fifo_rd_en, win_valid, win_data, frame_done, win_row, win_col
   );
`else
   modport master (
      input  fifo_empty, fifo_dout, win_ready,
      output fifo_rd_en, win_valid, win_data, frame_done
   );
   modport slave (
      output fifo_empty, fifo_dout, win_ready,
      input  fifo_rd_en, win_valid, win_data, frame_done
   );
`endif

endinterface

// File: rtl/sift_line_buf.sv
// Single-address line buffer: synchronous write, and the read returns the pre-write
// contents of the same address within the cycle.
module sift_line_buf #(
   parameter int DEPTH = 320,
   parameter int AW    = 9,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem [DEPTH];

   // NOTE: the array has no reset; lines 0-1 of a frame are never emitted, so stale data is harmless.
   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= din;
   end

   assign dout = mem[addr];

endmodule

// File: rtl/sift_win3x3_feeder.sv
// Pulls pixels from the pixel FIFO and emits one registered 3x3 window per interior pixel.
// Optional macro WIN_COORD_EN adds the win_row/win_col centre-tap outputs.
module sift_win3x3_feeder
   import sift_win_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int COL_W = 9,
   parameter int ROW_W = 8
) (
   input logic                  clk,
   input logic                  rst,
   sift_win3x3_feeder_if.master bus
);

   logic             pix_vld;
   logic             skid_full;
   pix_t             skid_data;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   col_t             hist0;
   col_t             hist1;
   col_t             new_col;
   pix_t             pix_in;
   pix_t             lb0_q;
   pix_t             lb1_q;
   logic             win_valid;
   logic [WIN_W-1:0] win_data;
   logic [WIN_W-1:0] win_next;
   logic             frame_done;
   logic             out_free;
   logic             accept;
   logic             skid_load;
   logic             last_col;
   logic             last_row;
   logic             interior;

   assign out_free  = !win_valid || bus.win_ready;
   assign accept    = (pix_vld || skid_full) && out_free;
   // An arrival that cannot be taken this cycle parks in the skid.
   assign skid_load = pix_vld && (skid_full || !out_free);
   assign pix_in    = skid_full ? skid_data : bus.fifo_dout;
   assign last_col  = (col == COL_W'(IMG_W - 1));
   assign last_row  = (row == ROW_W'(IMG_H - 1));
   assign interior  = (row >= ROW_W'(2)) && (col >= COL_W'(2));

   assign bus.fifo_rd_en = !rst && !bus.fifo_empty && !skid_full && out_free;

   sift_line_buf #(.DEPTH(IMG_W), .AW(COL_W), .DW(PIX_W)) lb0 (
      .clk   (clk),
      .wr_en (accept),
      .addr  (col),
      .din   (pix_in),
      .dout  (lb0_q)
   );

   sift_line_buf #(.DEPTH(IMG_W), .AW(COL_W), .DW(PIX_W)) lb1 (
      .clk   (clk),
      .wr_en (accept),
      .addr  (col),
      .din   (lb0_q),
      .dout  (lb1_q)
   );

   // NOTE: every always_comb output gets a default first, so no path can leave a latch.
   always_comb begin
      new_col  = {pix_in, lb0_q, lb1_q};
      win_next = '0;
      for (int r = 0; r < WIN_K; r++) begin
         win_next[tap(r, 0) +: PIX_W] = hist0[r];
         win_next[tap(r, 1) +: PIX_W] = hist1[r];
         win_next[tap(r, 2) +: PIX_W] = new_col[r];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_vld    <= 1'b0;
         skid_full  <= 1'b0;
         skid_data  <= '0;
         col        <= '0;
         row        <= '0;
         hist0      <= '0;
         hist1      <= '0;
         win_valid  <= 1'b0;
         win_data   <= '0;
         frame_done <= 1'b0;
      end else begin
         pix_vld <= bus.fifo_rd_en;

         if (skid_load) begin
            skid_full <= 1'b1;
            skid_data <= bus.fifo_dout;
         end else if (accept) begin
            skid_full <= 1'b0;
         end

         if (accept) begin
            hist0 <= hist1;
            hist1 <= new_col;
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end

         frame_done <= accept && last_col && last_row;

         if (accept && interior) begin
            win_valid <= 1'b1;
            win_data  <= win_next;
         end else if (bus.win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

`ifdef WIN_COORD_EN
   logic [ROW_W-1:0] win_row;
   logic [COL_W-1:0] win_col;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_row <= '0;
         win_col <= '0;
      end else if (accept && interior) begin
         win_row <= row - 1'b1;
         win_col <= col - 1'b1;
      end
   end

   assign bus.win_row = win_row;
   assign bus.win_col = win_col;
`endif

   assign bus.win_valid  = win_valid;
   assign bus.win_data   = win_data;
   assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_sift_win3x3_feeder.sv
// Directed bench for sift_win3x3_feeder on an 8x4 image whose pixels are row*16+col.
module tb_sift_win3x3_feeder;
   import sift_win_pkg::*;

   localparam int IMG_W     = 8;
   localparam int IMG_H     = 4;
   localparam int COL_W     = 3;
   localparam int ROW_W     = 2;
   localparam int FRAME_WIN = (IMG_W - 2) * (IMG_H - 2);

   logic clk = 1'b0;
   logic rst = 1'b1;

`ifdef WIN_COORD_EN
   sift_win3x3_feeder_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();
`else
   sift_win3x3_feeder_if bus ();
`endif

   sift_win3x3_feeder #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    frames;
      int    stall_at;
      int    stall_len;
      bit    underrun;
      int    exp_windows;
      int    exp_done;
      int    exp_first_win;
   } vec_t;

   int               total = 0;
   int               bad   = 0;
   logic [7:0]       fifo_q[$];
   logic [7:0]       pend_data;
   bit               pend_valid;
   int               cyc, win_cnt, done_cnt, first_rd, first_win, rd_cnt;
   logic [WIN_W-1:0] first_data, last_data;

   task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Window k of a frame: centre (1 + k/6, 1 + k%6), tap p[r][c] = pixel(cr-1+r, cc-1+c).
   function automatic logic [WIN_W-1:0] exp_win(input int k);
      int i, cr, cc;
      logic [WIN_W-1:0] w;
      i  = k % FRAME_WIN;
      cr = 1 + i / (IMG_W - 2);
      cc = 1 + i % (IMG_W - 2);
      w  = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[(3 * r + c) * 8 +: 8] = 8'((cr - 1 + r) * 16 + (cc - 1 + c));
      return w;
   endfunction

   task automatic cycle(input bit rdy, input bit blk);
      @(negedge clk);
      if (pend_valid) bus.fifo_dout = pend_data;
      bus.win_ready  = rdy;
      bus.fifo_empty = blk || (fifo_q.size() == 0);
      #1;
      pend_valid = 1'b0;
      if (bus.fifo_rd_en) begin
         check("rd_while_empty", bus.fifo_empty, 1'b0);
         if (first_rd < 0) first_rd = cyc;
         rd_cnt++;
         if (fifo_q.size() > 0) begin
            pend_data  = fifo_q.pop_front();
            pend_valid = 1'b1;
         end
      end
      if (bus.win_valid && !bus.win_ready) check("stall_rd_en", bus.fifo_rd_en, 1'b0);
      if (bus.frame_done) begin
         done_cnt++;
         check("done_on_last", {bus.win_valid, 1'((win_cnt % FRAME_WIN) == FRAME_WIN - 1)}, 2'b11);
      end
      if (bus.win_valid) begin
         if (first_win < 0) begin
            first_win  = cyc;
            first_data = bus.win_data;
         end
         check("win_data", bus.win_data, exp_win(win_cnt));
`ifdef WIN_COORD_EN
         begin
            int i;
            i = win_cnt % FRAME_WIN;
            check("win_row", bus.win_row, 1 + i / (IMG_W - 2));
            check("win_col", bus.win_col, 1 + i % (IMG_W - 2));
         end
`endif
         if (bus.win_ready) begin
            last_data = bus.win_data;
            win_cnt++;
         end
      end
      cyc++;
   endtask

   // Asserts rst just after a rising edge, reloads the FIFO, checks reset outputs, releases.
   task automatic do_reset(input int frames);
      @(posedge clk);
      #1;
      rst = 1'b1;
      fifo_q.delete();
      for (int f = 0; f < frames; f++)
         for (int i = 0; i < IMG_W * IMG_H; i++)
            fifo_q.push_back(8'(((i / IMG_W) << 4) | (i % IMG_W)));
      pend_valid = 1'b0;
      @(negedge clk);
      bus.win_ready  = 1'b1;
      bus.fifo_empty = (fifo_q.size() == 0);
      #1;
      check("rst_rd_en", bus.fifo_rd_en, 1'b0);
      check("rst_win_valid", bus.win_valid, 1'b0);
      check("rst_win_data", bus.win_data, '0);
      check("rst_frame_done", bus.frame_done, 1'b0);
`ifdef WIN_COORD_EN
      check("rst_win_row", bus.win_row, '0);
      check("rst_win_col", bus.win_col, '0);
`endif
      @(posedge clk);
      #1;
      rst        = 1'b0;
      cyc        = 0;
      win_cnt    = 0;
      done_cnt   = 0;
      first_rd   = -1;
      first_win  = -1;
      rd_cnt     = 0;
      first_data = 'x;
      last_data  = 'x;
   endtask

   initial begin
      vec_t vecs[4];
      vecs[0] = '{name:"streaming", frames:1, stall_at:-1, stall_len:0, underrun:1'b0,
                  exp_windows:12, exp_done:1, exp_first_win:20};
      vecs[1] = '{name:"backpressure", frames:1, stall_at:24, stall_len:5, underrun:1'b0,
                  exp_windows:12, exp_done:1, exp_first_win:20};
      vecs[2] = '{name:"underrun", frames:1, stall_at:-1, stall_len:0, underrun:1'b1,
                  exp_windows:12, exp_done:1, exp_first_win:-1};
      vecs[3] = '{name:"frame_wrap", frames:2, stall_at:-1, stall_len:0, underrun:1'b0,
                  exp_windows:24, exp_done:2, exp_first_win:20};

      bus.fifo_empty = 1'b1;
      bus.fifo_dout  = '0;
      bus.win_ready  = 1'b1;
      pend_valid     = 1'b0;
      repeat (3) @(posedge clk);

      for (int v = 0; v < 4; v++) begin
         do_reset(vecs[v].frames);
         for (int n = 0; n < vecs[v].frames * 100 + 40; n++)
            cycle(!(vecs[v].stall_at >= 0 && n >= vecs[v].stall_at &&
                    n < vecs[v].stall_at + vecs[v].stall_len),
                  vecs[v].underrun && (n % 2 == 1));
         check({vecs[v].name, "_windows"}, win_cnt, vecs[v].exp_windows);
         check({vecs[v].name, "_frame_done"}, done_cnt, vecs[v].exp_done);
         check({vecs[v].name, "_fifo_drained"}, fifo_q.size(), 0);
         check({vecs[v].name, "_idle"}, bus.win_valid, 1'b0);
         if (vecs[v].exp_first_win >= 0) begin
            check({vecs[v].name, "_first_rd_cycle"}, first_rd, 0);
            check({vecs[v].name, "_first_win_cycle"}, first_win, vecs[v].exp_first_win);
         end
      end

      // Latency and tap placement of the first and last window of a streamed frame.
      do_reset(1);
      for (int n = 0; n < 80; n++) cycle(1'b1, 1'b0);
      check("lat_first_rd", first_rd, 0);
      check("lat_first_win", first_win, 20);
      check("lat_p00", first_data[0 +: 8], 8'h00);
      check("lat_p01", first_data[8 +: 8], 8'h01);
      check("lat_p02", first_data[16 +: 8], 8'h02);
      check("lat_p10", first_data[24 +: 8], 8'h10);
      check("lat_p11", first_data[32 +: 8], 8'h11);
      check("lat_p12", first_data[40 +: 8], 8'h12);
      check("lat_p20", first_data[48 +: 8], 8'h20);
      check("lat_p21", first_data[56 +: 8], 8'h21);
      check("lat_p22", first_data[64 +: 8], 8'h22);
      check("last_p22", last_data[64 +: 8], 8'h37);
      check("last_p00", last_data[0 +: 8], 8'h15);

      // Reset with the 14th pixel in flight: it must be dropped and the frame restart at (0,0).
      do_reset(1);
      begin
         int n;
         n = 0;
         while (rd_cnt < 14 && n < 60) begin
            cycle(1'b1, 1'b0);
            n++;
         end
      end
      check("mid_reads_before_rst", rd_cnt, 14);
      check("mid_no_early_window", win_cnt, 0);
      do_reset(1);
      for (int n = 0; n < 140; n++) cycle(1'b1, 1'b0);
      check("mid_windows", win_cnt, 12);
      check("mid_frame_done", done_cnt, 1);
      check("mid_first_win", first_win, 20);
      check("mid_first_p11", first_data[32 +: 8], 8'h11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
